dmem_access_unit: RTL and testbench

- Memory-stage load/store responder between the pipeline's M-stage memory controls (memen, memwrite) and an SRAM-like data bus with address/data handshake.
- Generates byte selects and store-data replication, detects misaligned addresses, and holds the pipeline via stall_req while a bus transaction is outstanding.
- Returns aligned, sign/zero-extended load data to the M stage.

---
 rtl/dmem_access_unit_if.sv | 25 ++
 rtl/dmem_access_unit.sv | 181 ++++++++++++++++++
 tb/tb_dmem_access_unit.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/dmem_access_unit_if.sv
// Data-side SRAM-like bus between the memory-stage access unit and memory.
// Address phase is req/addr_ok; data phase completes on data_ok.
interface dmem_access_unit_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          data_req;
    logic          data_wr;
    logic [3:0]    data_sel;
    logic [AW-1:0] data_addr;
    logic [DW-1:0] data_wdata;
    logic          data_addr_ok;
    logic          data_data_ok;
    logic [DW-1:0] data_rdata;

    modport master (
        output data_req, data_wr, data_sel, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata
    );

    modport slave (
        input  data_req, data_wr, data_sel, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata
    );
endinterface

// File: rtl/dmem_access_unit.sv
// Memory-stage load/store responder: lane generation, misalignment checks,
// bus handshake sequencing and load-data extension.
module dmem_access_unit #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          memen_m,
    input  logic          memwrite_m,
    input  logic [1:0]    ls_size_m,
    input  logic          ls_unsigned_m,
    input  logic [AW-1:0] addr_m,
    input  logic [DW-1:0] wdata_m,
    input  logic          flush,
    output logic          stall_req,
    output logic [DW-1:0] rdata_m,
    output logic          adel,
    output logic          ades,
    output logic [AW-1:0] bad_addr,
    dmem_access_unit_if.master bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic          req_q, req_d;
    logic          wr_q, wr_d;
    logic [3:0]    sel_q, sel_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [1:0]    lo_q, lo_d;
    logic [1:0]    size_q, size_d;
    logic          uns_q, uns_d;
    logic          flushed_q, flushed_d;
    logic [DW-1:0] rdata_q, rdata_d;

    logic          is_byte, is_half, is_word;
    logic          mis, go, kill;
    logic [3:0]    sel_n;
    logic [DW-1:0] wd_n, ld_ext;
    logic [7:0]    ld_b;
    logic [15:0]   ld_h;

    assign is_byte  = (ls_size_m == 2'b00);
    assign is_half  = (ls_size_m == 2'b01);
    assign is_word  = ls_size_m[1];
    assign mis      = (is_half & addr_m[0]) | (is_word & (|addr_m[1:0]));
    assign go       = memen_m & ~mis & ~flush;
    assign adel     = memen_m & ~memwrite_m & mis;
    assign ades     = memen_m & memwrite_m & mis;
    assign bad_addr = addr_m;

    always_comb begin
        sel_n = 4'b1111;
        wd_n  = wdata_m;
        unique case (1'b1)
            is_byte: begin
                sel_n = 4'b0001 << addr_m[1:0];
                wd_n  = {4{wdata_m[7:0]}};
            end
            is_half: begin
                sel_n = addr_m[1] ? 4'b1100 : 4'b0011;
                wd_n  = {2{wdata_m[15:0]}};
            end
            default: ;
        endcase
    end

    // Extraction is driven by the latched access, not the live M-stage inputs.
    always_comb begin
        ld_b = bus.data_rdata[8*lo_q +: 8];
        ld_h = lo_q[1] ? bus.data_rdata[31:16] : bus.data_rdata[15:0];
        ld_ext = bus.data_rdata;
        if (size_q == 2'b00) begin
            ld_ext = {{24{~uns_q & ld_b[7]}}, ld_b};
        end else if (size_q == 2'b01) begin
            ld_ext = {{16{~uns_q & ld_h[15]}}, ld_h};
        end
    end

    assign kill = flushed_q | flush;

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        wr_d      = wr_q;
        sel_d     = sel_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        lo_d      = lo_q;
        size_d    = size_q;
        uns_d     = uns_q;
        flushed_d = flushed_q;
        rdata_d   = rdata_q;
        stall_req = 1'b0;
        unique case (state_q)
            IDLE: begin
                stall_req = go;
                flushed_d = 1'b0;
                if (go) begin
                    req_d   = 1'b1;
                    wr_d    = memwrite_m;
                    sel_d   = sel_n;
                    addr_d  = {addr_m[AW-1:2], 2'b00};
                    wdata_d = wd_n;
                    lo_d    = addr_m[1:0];
                    size_d  = ls_size_m;
                    uns_d   = ls_unsigned_m;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                stall_req = 1'b1;
                flushed_d = kill;
                if (bus.data_addr_ok) begin
                    req_d = 1'b0;
                    if (bus.data_data_ok) begin
                        state_d = kill ? IDLE : DONE;
                        if (!kill && !wr_q) rdata_d = ld_ext;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                stall_req = 1'b1;
                flushed_d = kill;
                if (bus.data_data_ok) begin
                    state_d = kill ? IDLE : DONE;
                    if (!kill && !wr_q) rdata_d = ld_ext;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            req_q     <= 1'b0;
            wr_q      <= 1'b0;
            sel_q     <= 4'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            lo_q      <= 2'b0;
            size_q    <= 2'b0;
            uns_q     <= 1'b0;
            flushed_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            wr_q      <= wr_d;
            sel_q     <= sel_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            lo_q      <= lo_d;
            size_q    <= size_d;
            uns_q     <= uns_d;
            flushed_q <= flushed_d;
            rdata_q   <= rdata_d;
        end
    end

    assign bus.data_req   = req_q;
    assign bus.data_wr    = wr_q;
    assign bus.data_sel   = sel_q;
    assign bus.data_addr  = addr_q;
    assign bus.data_wdata = wdata_q;
    assign rdata_m        = rdata_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit: loads, stores, misalignment,
// flush draining, reset abandonment and back-to-back accesses.
module tb_dmem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        memen_m, memwrite_m, ls_unsigned_m, flush;
    logic [1:0]  ls_size_m;
    logic [31:0] addr_m, wdata_m;
    logic        stall_req, adel, ades;
    logic [31:0] rdata_m, bad_addr;
    logic [1:0]  st;

    int checks = 0;
    int errors = 0;

    dmem_access_unit_if #(.AW(32), .DW(32)) bus_if ();

    dmem_access_unit #(.AW(32), .DW(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .memen_m       (memen_m),
        .memwrite_m    (memwrite_m),
        .ls_size_m     (ls_size_m),
        .ls_unsigned_m (ls_unsigned_m),
        .addr_m        (addr_m),
        .wdata_m       (wdata_m),
        .flush         (flush),
        .stall_req     (stall_req),
        .rdata_m       (rdata_m),
        .adel          (adel),
        .ades          (ades),
        .bad_addr      (bad_addr),
        .bus           (bus_if)
    );

    assign st = dut.state_q;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic op(input logic en, input logic we, input logic [1:0] sz,
                      input logic uns, input logic [31:0] a,
                      input logic [31:0] wd);
        memen_m       = en;
        memwrite_m    = we;
        ls_size_m     = sz;
        ls_unsigned_m = uns;
        addr_m        = a;
        wdata_m       = wd;
    endtask

    task automatic bus_in(input logic aok, input logic dok,
                          input logic [31:0] rd);
        bus_if.data_addr_ok = aok;
        bus_if.data_data_ok = dok;
        bus_if.data_rdata   = rd;
    endtask

    // Inputs change on the falling edge; checks follow 1 ns later.
    task automatic cyc;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        flush = 1'b0;
        op(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        bus_in(1'b0, 1'b0, 32'h0);
        cyc(); cyc();
        rst = 1'b1;
        #1;
        chk("rst_req", {31'b0, bus_if.data_req}, 32'h0);
        chk("rst_stall", {31'b0, stall_req}, 32'h0);
        chk("rst_state", {30'b0, st}, 32'h0);
        chk("rst_rdata", rdata_m, 32'h0);

        // LB 0x1003, zero wait states
        cyc(); op(1'b1, 1'b0, 2'b00, 1'b0, 32'h1003, 32'h0); #1;
        chk("lb_stall0", {31'b0, stall_req}, 32'h1);
        cyc(); bus_in(1'b1, 1'b1, 32'h80FF_FFFF); #1;
        chk("lb_req", {31'b0, bus_if.data_req}, 32'h1);
        chk("lb_sel", {28'b0, bus_if.data_sel}, 32'h8);
        chk("lb_addr", bus_if.data_addr, 32'h1000);
        chk("lb_stall1", {31'b0, stall_req}, 32'h1);
        cyc(); bus_in(1'b0, 1'b0, 32'h0); #1;
        chk("lb_done_st", {30'b0, st}, 32'h3);
        chk("lb_stall2", {31'b0, stall_req}, 32'h0);
        chk("lb_rdata", rdata_m, 32'hFFFF_FF80);
        chk("lb_req_off", {31'b0, bus_if.data_req}, 32'h0);

        // LBU same address
        cyc(); ls_unsigned_m = 1'b1; #1;
        chk("lbu_stall0", {31'b0, stall_req}, 32'h1);
        cyc(); bus_in(1'b1, 1'b1, 32'h80FF_FFFF); #1;
        cyc(); bus_in(1'b0, 1'b0, 32'h0); #1;
        chk("lbu_rdata", rdata_m, 32'h0000_0080);
        chk("lbu_stall", {31'b0, stall_req}, 32'h0);

        // SH 0x2002, addr_ok delayed 3 cycles, early data_ok ignored
        cyc(); op(1'b1, 1'b1, 2'b01, 1'b0, 32'h2002, 32'h1234_ABCD); #1;
        chk("sh_stall0", {31'b0, stall_req}, 32'h1);
        for (int i = 0; i < 3; i++) begin
            cyc(); bus_in(1'b0, (i == 1), 32'h0); #1;
            chk("sh_req_wait", {31'b0, bus_if.data_req}, 32'h1);
            chk("sh_state_wait", {30'b0, st}, 32'h1);
        end
        cyc(); bus_in(1'b1, 1'b0, 32'h0); #1;
        chk("sh_req4", {31'b0, bus_if.data_req}, 32'h1);
        chk("sh_sel", {28'b0, bus_if.data_sel}, 32'hC);
        chk("sh_wdata", bus_if.data_wdata, 32'hABCD_ABCD);
        chk("sh_wr", {31'b0, bus_if.data_wr}, 32'h1);
        chk("sh_addr", bus_if.data_addr, 32'h2000);
        cyc(); bus_in(1'b0, 1'b1, 32'h0); #1;
        chk("sh_data_req", {31'b0, bus_if.data_req}, 32'h0);
        chk("sh_data_stall", {31'b0, stall_req}, 32'h1);
        cyc(); bus_in(1'b0, 1'b0, 32'h0); #1;
        chk("sh_done_stall", {31'b0, stall_req}, 32'h0);
        chk("sh_rdata_keep", rdata_m, 32'h0000_0080);

        // Misaligned accesses
        cyc(); op(1'b1, 1'b0, 2'b10, 1'b0, 32'h3001, 32'h0); #1;
        chk("lw_adel", {31'b0, adel}, 32'h1);
        chk("lw_ades", {31'b0, ades}, 32'h0);
        chk("lw_bad", bad_addr, 32'h3001);
        chk("lw_mis_stall", {31'b0, stall_req}, 32'h0);
        cyc(); op(1'b1, 1'b1, 2'b10, 1'b0, 32'h3002, 32'h0); #1;
        chk("lw_mis_req", {31'b0, bus_if.data_req}, 32'h0);
        chk("sw_ades", {31'b0, ades}, 32'h1);
        chk("sw_adel", {31'b0, adel}, 32'h0);
        chk("sw_bad", bad_addr, 32'h3002);
        cyc(); op(1'b1, 1'b1, 2'b01, 1'b0, 32'h2001, 32'h0); #1;
        chk("sh_ades", {31'b0, ades}, 32'h1);
        chk("sw_mis_req", {31'b0, bus_if.data_req}, 32'h0);
        cyc(); op(1'b1, 1'b0, 2'b11, 1'b0, 32'h3002, 32'h0); #1;
        chk("rsv_adel", {31'b0, adel}, 32'h1);

        // Flush suppresses start in IDLE
        cyc(); op(1'b1, 1'b0, 2'b10, 1'b0, 32'h4000, 32'h0); flush = 1'b1; #1;
        chk("flush_idle_stall", {31'b0, stall_req}, 32'h0);
        cyc(); flush = 1'b0; #1;
        chk("flush_idle_req", {31'b0, bus_if.data_req}, 32'h0);

        // LW accepted, flushed in DATA, drains on data_ok
        chk("fl_stall0", {31'b0, stall_req}, 32'h1);
        cyc(); bus_in(1'b1, 1'b0, 32'h0); #1;
        cyc(); bus_in(1'b0, 1'b0, 32'h0); flush = 1'b1; #1;
        chk("fl_state_data", {30'b0, st}, 32'h2);
        chk("fl_stall1", {31'b0, stall_req}, 32'h1);
        cyc(); flush = 1'b0; #1;
        chk("fl_stall2", {31'b0, stall_req}, 32'h1);
        cyc(); bus_in(1'b0, 1'b1, 32'hDEAD_BEEF); #1;
        chk("fl_stall3", {31'b0, stall_req}, 32'h1);
        cyc(); bus_in(1'b0, 1'b0, 32'h0); op(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0); #1;
        chk("fl_state_idle", {30'b0, st}, 32'h0);
        chk("fl_rdata_keep", rdata_m, 32'h0000_0080);
        chk("fl_stall4", {31'b0, stall_req}, 32'h0);

        // Reset while in ADDR
        cyc(); op(1'b1, 1'b1, 2'b10, 1'b0, 32'h5000, 32'hCAFE_F00D); #1;
        cyc(); rst = 1'b0; #1;
        chk("rs_req_before", {31'b0, bus_if.data_req}, 32'h1);
        cyc(); rst = 1'b1; op(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0); #1;
        chk("rs_req", {31'b0, bus_if.data_req}, 32'h0);
        chk("rs_state", {30'b0, st}, 32'h0);
        chk("rs_wr", {31'b0, bus_if.data_wr}, 32'h0);
        chk("rs_sel", {28'b0, bus_if.data_sel}, 32'h0);
        chk("rs_addr", bus_if.data_addr, 32'h0);
        chk("rs_wdata", bus_if.data_wdata, 32'h0);
        chk("rs_rdata", rdata_m, 32'h0);

        // Back-to-back LW then SW after reset
        cyc(); op(1'b1, 1'b0, 2'b10, 1'b0, 32'h6004, 32'h0); #1;
        chk("b2b_lw_stall", {31'b0, stall_req}, 32'h1);
        cyc(); bus_in(1'b1, 1'b1, 32'h1122_3344); #1;
        chk("b2b_lw_addr", bus_if.data_addr, 32'h6004);
        chk("b2b_lw_sel", {28'b0, bus_if.data_sel}, 32'hF);
        cyc(); bus_in(1'b0, 1'b0, 32'h0); op(1'b1, 1'b1, 2'b10, 1'b0, 32'h6008, 32'h5566_7788); #1;
        chk("b2b_lw_rdata", rdata_m, 32'h1122_3344);
        chk("b2b_done_stall", {31'b0, stall_req}, 32'h0);
        cyc(); #1;
        chk("b2b_sw_stall", {31'b0, stall_req}, 32'h1);
        cyc(); bus_in(1'b1, 1'b1, 32'hFFFF_FFFF); #1;
        chk("b2b_sw_wr", {31'b0, bus_if.data_wr}, 32'h1);
        chk("b2b_sw_addr", bus_if.data_addr, 32'h6008);
        chk("b2b_sw_wdata", bus_if.data_wdata, 32'h5566_7788);
        cyc(); bus_in(1'b0, 1'b0, 32'h0); op(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0); #1;
        chk("b2b_sw_rdata", rdata_m, 32'h1122_3344);

        // LH then LHU, second presented in the DONE cycle
        cyc(); op(1'b1, 1'b0, 2'b01, 1'b0, 32'h7002, 32'h0); #1;
        cyc(); bus_in(1'b1, 1'b1, 32'h8001_0000); #1;
        chk("lh_sel", {28'b0, bus_if.data_sel}, 32'hC);
        cyc(); bus_in(1'b0, 1'b0, 32'h0); op(1'b1, 1'b0, 2'b01, 1'b1, 32'h7000, 32'h0); #1;
        chk("lh_done_st", {30'b0, st}, 32'h3);
        chk("lh_rdata", rdata_m, 32'hFFFF_8001);
        cyc(); #1;
        chk("lhu_idle_req", {31'b0, bus_if.data_req}, 32'h0);
        chk("lhu_idle_stall", {31'b0, stall_req}, 32'h1);
        cyc(); bus_in(1'b1, 1'b1, 32'h1234_F00F); #1;
        chk("lhu_req", {31'b0, bus_if.data_req}, 32'h1);
        chk("lhu_sel", {28'b0, bus_if.data_sel}, 32'h3);
        cyc(); bus_in(1'b0, 1'b0, 32'h0); op(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0); #1;
        chk("lhu_rdata", rdata_m, 32'h0000_F00F);

        cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
